// File: rtl/mdu_pkg.sv
// Shared constants, op encodings and FSM states for the iterative multiply/divide unit.
// Pure declarations; no logic, no latency, no flow control.
package mdu_pkg;

  localparam int XLEN  = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MULT  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// Unsigned shift-add multiply / restoring divide datapath, one result bit per step.
// acc_nxt is the combinational next step so the caller can capture the final bit with no extra cycle.
module mdu_iter_core
  import mdu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic [2*XLEN-1:0] acc_nxt,
  output logic              last
);

  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [CNT_W-1:0]  cnt;
  logic              div_r;

  logic [XLEN:0]     sum;
  logic [XLEN:0]     rem;
  logic [XLEN-1:0]   diff;
  logic              ge;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, remaining dividend bits / quotient bits}.
  always_comb begin
    sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    rem     = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    ge      = (rem >= {1'b0, opnd});
    diff    = rem[XLEN-1:0] - opnd;
    acc_nxt = div_r ? {(ge ? diff : rem[XLEN-1:0]), acc[XLEN-2:0], ge}
                    : {sum, acc[XLEN-1:1]};
    last    = (cnt == CNT_W'(ITERS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      opnd  <= '0;
      cnt   <= '0;
      div_r <= 1'b0;
    end else if (load) begin
      acc   <= {{XLEN{1'b0}}, (is_div ? op_a : op_b)};
      opnd  <= is_div ? op_b : op_a;
      cnt   <= '0;
      div_r <= is_div;
    end else if (step) begin
      acc   <= acc_nxt;
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: 33 cycles start-to-done, start ignored while busy or in FIN, MTHI/MTLO only in IDLE.
// MDU_SIGNED_EN adds signed MULT/DIV via launch-time magnitudes and a sign fix folded into the FIN write.
module mult_div_unit
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wr_data,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  state_e            state;
  logic              launch;
  logic              dz_r;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [2*XLEN-1:0] acc_nxt;
  logic              last;
  logic [XLEN-1:0]   res_hi;
  logic [XLEN-1:0]   res_lo;

  assign launch = (state == IDLE) && start;

`ifdef MDU_SIGNED_EN
  logic a_neg, b_neg;
  logic op_div_r, neg_q_r, neg_r_r;

  assign a_neg = op[1] & rs_data[XLEN-1];
  assign b_neg = op[1] & rt_data[XLEN-1];
  assign a_mag = a_neg ? (~rs_data + 1'b1) : rs_data;
  assign b_mag = b_neg ? (~rt_data + 1'b1) : rt_data;
`else
  logic op_hi_unused;

  assign op_hi_unused = op[1];
  assign a_mag = rs_data;
  assign b_mag = rt_data;
`endif

  mdu_iter_core u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (launch),
    .step    (state == RUN),
    .is_div  (op[0]),
    .op_a    (a_mag),
    .op_b    (b_mag),
    .acc_nxt (acc_nxt),
    .last    (last)
  );

  always_comb begin
    res_hi = acc_nxt[2*XLEN-1:XLEN];
    res_lo = acc_nxt[XLEN-1:0];
`ifdef MDU_SIGNED_EN
    if (op_div_r) begin
      if (neg_q_r) res_lo = ~acc_nxt[XLEN-1:0] + 1'b1;
      if (neg_r_r) res_hi = ~acc_nxt[2*XLEN-1:XLEN] + 1'b1;
    end else if (neg_q_r) begin
      {res_hi, res_lo} = ~acc_nxt + 1'b1;
    end
`endif
    // Remainder path already yields the dividend in HI; only LO needs forcing.
    if (dz_r) res_lo = '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      dz_r        <= 1'b0;
`ifdef MDU_SIGNED_EN
      op_div_r    <= 1'b0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
`endif
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wr_data;
          if (lo_we) lo <= wr_data;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            dz_r  <= op[0] && (rt_data == '0);
`ifdef MDU_SIGNED_EN
            op_div_r <= op[0];
            neg_q_r  <= a_neg ^ b_neg;
            neg_r_r  <= a_neg;
`endif
          end
        end
        RUN: begin
          if (last) begin
            state       <= FIN;
            busy        <= 1'b0;
            done        <= 1'b1;
            div_by_zero <= dz_r;
            hi          <= res_hi;
            lo          <= res_lo;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit; consumes the two register-file read operands (rs, rt) and owns the HI/LO result registers.
- Sits beside the ALU in the execute stage; the controller stalls the single-cycle PC while busy=1.
- HI/LO are read back through the write-back mux (MFHI/MFLO) and written directly by MTHI/MTLO.

Parameters:
- XLEN, 32, operand and HI/LO width.
- ITERS, 32, iteration cycles per operation (equals XLEN; one result bit per cycle).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  launch operation; sampled only in IDLE.
- op  input  2  00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
- rs_data  input  XLEN  operand A (multiplicand / dividend).
- rt_data  input  XLEN  operand B (multiplier / divisor).
- hi_we  input  1  MTHI write strobe.
- lo_we  input  1  MTLO write strobe.
- wr_data  input  XLEN  MTHI/MTLO data.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse; HI/LO updated the same cycle.
- div_by_zero  output  1  valid with done; divide with rt_data == 0.
- hi  output  XLEN  HI register (remainder / product upper half).
- lo  output  XLEN  LO register (quotient / product lower half).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0. Applies immediately, including mid-operation; the in-flight operation is discarded.
- FSM states: IDLE, RUN, FIN.
  - IDLE: start=1 at edge N latches op and operands and goes to RUN. busy=1 from N+1.
  - RUN: one shift-add (multiply) or restoring subtract-shift (divide) step per cycle. A 6-bit counter runs 0 to ITERS-1. After ITERS cycles, go to FIN.
  - FIN: HI/LO written at this edge. done=1 for exactly one cycle at N+ITERS+1, busy=0 in that same cycle. Return to IDLE.
- Total latency from start to done: ITERS+1 = 33 cycles. HI/LO hold their old values until FIN.
- Multiply: 2*XLEN-bit product. hi = product[63:32], lo = product[31:0].
- Divide: lo = quotient, hi = remainder.
- Divide by zero: still runs 33 cycles. Result lo=0xFFFFFFFF, hi=rs_data; div_by_zero=1 with done.
- start while busy or in FIN: ignored; no queueing.
- hi_we/lo_we in IDLE: the register is loaded at the next edge. While busy, they are ignored.
- start and hi_we/lo_we in the same IDLE cycle: MTHI/MTLO write takes effect, the operation launches, and FIN later overwrites both registers.
- done and div_by_zero are registered outputs; no combinational path from inputs to outputs.

Optional Feature:
- Macro MDU_SIGNED_EN.
- Defined: op 10/11 are signed.
  - Operands are converted to magnitudes at launch. Sign is fixed in FIN with no extra cycle.
  - Product sign = sign(A) xor sign(B). Quotient sign = sign(A) xor sign(B). Remainder sign = sign(A). Division truncates toward zero.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - Signed divide by zero: lo=0xFFFFFFFF, hi=rs_data.
- Undefined: op[1] is ignored; 10/11 execute exactly as 00/01. No sign-fix logic is synthesized.

Decomposition:
- Package mdu_pkg holds:
  - op encodings (OP_MULTU, OP_DIVU, OP_MULT, OP_DIV);
  - XLEN and ITERS constants;
  - FSM state encoding (IDLE/RUN/FIN).
- One sub-module, mdu_iter_core: owns the 64-bit accumulator/remainder, the operand shift registers and the iteration counter.
- The top level keeps the FSM, sign handling, HI/LO registers and MTHI/MTLO.

Test Plan:
- MULTU: 0xFFFFFFFF * 0xFFFFFFFF -> done at cycle 33, hi=0xFFFFFFFE, lo=0x00000001; busy high for cycles 1-32.
- DIVU: 100 / 7 -> lo=14, hi=2, div_by_zero=0. Then DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1 with done.
- Busy lockout: MULTU 3*4 in flight, then start with DIVU at cycle 5 plus hi_we with 0xDEAD -> second op ignored, hi=0, lo=12.
- Reset mid-op: start DIVU 1000/3, drop rst_n at cycle 10 -> busy, hi and lo go to 0 without waiting for an edge. Then MULTU 6*7 -> lo=42, hi=0.
- MTHI/MTLO in IDLE: lo_we with 0x12345678, then hi_we with 0xCAFEF00D -> values visible the next cycle and held until the next FIN.
- MDU_SIGNED_EN, defined:
  - MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MDU_SIGNED_EN, undefined: MULT 0xFFFFFFFD*5 -> hi=0x00000004, lo=0xFFFFFFF1.
